// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipeline.
// Holds a 256x16 data memory, a two-state load FSM, the ALU write-back
// register and the registered branch resolution.
// Build option: define MEM_FWD_EN to add the MEM-to-EX forwarding register
// that drives dataMem; without it dataMem is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting a new instruction; a load request stalls upstream
// RD_WAIT  | load address latched; memory word is written back this edge
module mem_stage (
    input  logic        clock,
    input  logic        resetN,
    input  logic        WRMem,
    input  logic        WMMem,
    input  logic        RMMem,
    input  logic        NEQMem,
    input  logic        JMem,
    input  logic        JCMem,
    input  logic [15:0] acOutValue,
    input  logic [15:0] rs,
    input  logic [1:0]  rdIn,
    input  logic        zeroOut,
    input  logic [15:0] ulaJumpOut,
    output logic [15:0] wbData,
    output logic [1:0]  rdWb,
    output logic        WRWb,
    output logic        pcSrc,
    output logic [15:0] jumpAddr,
    output logic        flush,
    output logic        stall,
    output logic [15:0] dataMem
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_mem [0:255];
    logic [7:0]  r_addr;
    logic [1:0]  r_rd;
    logic [15:0] r_wb_data;
    logic [1:0]  r_rd_wb;
    logic        r_wr_wb;
    logic        r_pc_src;
    logic [15:0] r_jump_addr;
    logic        r_flush;

    logic        w_idle;
    logic        w_store;
    logic        w_load_req;
    logic        w_taken;

    // Decode of the instruction currently presented by EX.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_store    = w_idle & WMMem;
        w_load_req = w_idle & RMMem & ~WMMem;
        w_taken    = JMem | (JCMem & (NEQMem ? ~zeroOut : zeroOut));
    end

    // Stall is combinational so upstream freezes in the same cycle as the
    // load request; reset masks it because the request may be held high.
    assign stall = resetN & w_load_req;

    // Data memory: no reset, contents persist; stores are ignored in RD_WAIT.
    always_ff @(posedge clock) begin
        if (w_store) begin
            r_mem[acOutValue[7:0]] <= rs;
        end
    end

    // Load FSM with registered write-back and branch outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_rd        <= '0;
            r_wb_data   <= '0;
            r_rd_wb     <= '0;
            r_wr_wb     <= 1'b0;
            r_pc_src    <= 1'b0;
            r_jump_addr <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pc_src    <= w_taken;
                    r_flush     <= w_taken;
                    r_jump_addr <= ulaJumpOut;
                    if (WMMem) begin
                        r_wr_wb <= 1'b0;
                    end else if (RMMem) begin
                        r_addr  <= acOutValue[7:0];
                        r_rd    <= rdIn;
                        r_wr_wb <= 1'b0;
                        r_state <= ST_RD_WAIT;
                    end else if (WRMem) begin
                        r_wb_data <= acOutValue;
                        r_rd_wb   <= rdIn;
                        r_wr_wb   <= 1'b1;
                    end else begin
                        r_wr_wb <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    // Inputs are ignored here: upstream is held by stall.
                    r_wb_data <= r_mem[r_addr];
                    r_rd_wb   <= r_rd;
                    r_wr_wb   <= 1'b1;
                    r_pc_src  <= 1'b0;
                    r_flush   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbData   = r_wb_data;
    assign rdWb     = r_rd_wb;
    assign WRWb     = r_wr_wb;
    assign pcSrc    = r_pc_src;
    assign jumpAddr = r_jump_addr;
    assign flush    = r_flush;

`ifdef MEM_FWD_EN
    logic [15:0] r_fwd;
    logic        w_fwd_load;
    logic [15:0] w_fwd_value;

    // The forwarding copy is loaded on exactly the edges that set WRWb.
    always_comb begin
        w_fwd_load  = (r_state == ST_RD_WAIT) | (w_idle & WRMem & ~WMMem & ~RMMem);
        w_fwd_value = (r_state == ST_RD_WAIT) ? r_mem[r_addr] : acOutValue;
    end

    // Forwarding register: tracks wbData while WRWb=1, holds otherwise.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_fwd <= '0;
        end else if (w_fwd_load) begin
            r_fwd <= w_fwd_value;
        end
    end

    assign dataMem = r_fwd;
`else
    assign dataMem = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: behavioural model compared on every
// falling edge, plus literal expectations at key points.
module tb_mem_stage;

    logic        clock;
    logic        resetN;
    logic        WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;
    logic [15:0] acOutValue, rs, ulaJumpOut;
    logic [1:0]  rdIn;
    logic        zeroOut;
    logic [15:0] wbData, jumpAddr, dataMem;
    logic [1:0]  rdWb;
    logic        WRWb, pcSrc, flush, stall;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    mem_stage dut (
        .clock(clock), .resetN(resetN),
        .WRMem(WRMem), .WMMem(WMMem), .RMMem(RMMem), .NEQMem(NEQMem),
        .JMem(JMem), .JCMem(JCMem),
        .acOutValue(acOutValue), .rs(rs), .rdIn(rdIn), .zeroOut(zeroOut),
        .ulaJumpOut(ulaJumpOut),
        .wbData(wbData), .rdWb(rdWb), .WRWb(WRWb), .pcSrc(pcSrc),
        .jumpAddr(jumpAddr), .flush(flush), .stall(stall), .dataMem(dataMem)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [0:255];
    bit          m_pending;
    logic [7:0]  m_addr;
    logic [1:0]  m_rd;
    logic [15:0] e_wb, e_ja, e_dm;
    logic [1:0]  e_rd;
    logic        e_we, e_pc, e_flush;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_pending = 0; m_addr = 0; m_rd = 0;
            e_wb = 0; e_rd = 0; e_we = 0; e_pc = 0; e_ja = 0; e_flush = 0; e_dm = 0;
        end else begin
            if (m_pending) begin
                e_wb = m_mem[m_addr]; e_rd = m_rd; e_we = 1;
                e_pc = 0; e_flush = 0;
                m_pending = 0;
            end else begin
                bit taken;
                taken = JMem || (JCMem && (NEQMem ? !zeroOut : zeroOut));
                e_pc = taken; e_flush = taken; e_ja = ulaJumpOut;
                if (WMMem) begin
                    m_mem[acOutValue[7:0]] = rs; e_we = 0;
                end else if (RMMem) begin
                    m_pending = 1; m_addr = acOutValue[7:0]; m_rd = rdIn; e_we = 0;
                end else if (WRMem) begin
                    e_wb = acOutValue; e_rd = rdIn; e_we = 1;
                end else begin
                    e_we = 0;
                end
            end
`ifdef MEM_FWD_EN
            if (e_we) e_dm = e_wb;
`else
            e_dm = 0;
`endif
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_stall;
            exp_stall = resetN && !m_pending && RMMem && !WMMem;
            chk("m_wbData",   wbData,          e_wb);
            chk("m_rdWb",     {14'd0, rdWb},   {14'd0, e_rd});
            chk("m_WRWb",     {15'd0, WRWb},   {15'd0, e_we});
            chk("m_pcSrc",    {15'd0, pcSrc},  {15'd0, e_pc});
            chk("m_jumpAddr", jumpAddr,        e_ja);
            chk("m_flush",    {15'd0, flush},  {15'd0, e_flush});
            chk("m_stall",    {15'd0, stall},  {15'd0, exp_stall});
            chk("m_dataMem",  dataMem,         e_dm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        WRMem = 0; WMMem = 0; RMMem = 0; NEQMem = 0; JMem = 0; JCMem = 0;
        acOutValue = 0; rs = 0; rdIn = 0; zeroOut = 0; ulaJumpOut = 0;
    endtask

    task automatic load(input logic [15:0] a, input logic [1:0] rd);
        idle(); RMMem = 1; acOutValue = a; rdIn = rd;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        idle(); WMMem = 1; acOutValue = a; rs = d;
    endtask

    initial begin
        idle();
        resetN = 0;
        RMMem = 1;                       // load request held during reset
        step();
        chk("rst_wbData", wbData, 16'h0000);
        chk("rst_WRWb", {15'd0, WRWb}, 16'h0000);
        chk("rst_stall", {15'd0, stall}, 16'h0000);
        chk("rst_pcSrc", {15'd0, pcSrc}, 16'h0000);
        chk("rst_dataMem", dataMem, 16'h0000);
        idle();
        resetN = 1;
        chk_en = 1;

        // ALU write-back
        idle(); WRMem = 1; acOutValue = 16'h00A5; rdIn = 2'd1;
        step();
        chk("alu_wbData", wbData, 16'h00A5);
        chk("alu_WRWb", {15'd0, WRWb}, 16'h0001);
        chk("alu_rdWb", {14'd0, rdWb}, 16'h0001);
`ifdef MEM_FWD_EN
        chk("alu_dataMem", dataMem, 16'h00A5);
`else
        chk("alu_dataMem", dataMem, 16'h0000);
`endif
        idle();
        step();
        chk("hold_WRWb", {15'd0, WRWb}, 16'h0000);
        chk("hold_wbData", wbData, 16'h00A5);

        // store then load, with WRMem also set on the store
        store(16'h0010, 16'hBEEF); WRMem = 1;
        step();
        chk("st_WRWb", {15'd0, WRWb}, 16'h0000);
        load(16'h0010, 2'd2);
        #1;
        chk("ld_stall", {15'd0, stall}, 16'h0001);
        step();
        chk("ld_wait_stall", {15'd0, stall}, 16'h0000);
        chk("ld_wait_WRWb", {15'd0, WRWb}, 16'h0000);
        // inputs during RD_WAIT must be ignored
        idle(); WMMem = 1; acOutValue = 16'h0010; rs = 16'h0000; JMem = 1; ulaJumpOut = 16'h0099;
        step();
        chk("ld_wbData", wbData, 16'hBEEF);
        chk("ld_rdWb", {14'd0, rdWb}, 16'h0002);
        chk("ld_WRWb", {15'd0, WRWb}, 16'h0001);
        chk("ld_pcSrc", {15'd0, pcSrc}, 16'h0000);
        load(16'h0010, 2'd1);
        step();
        idle();
        step();
        chk("ld2_wbData", wbData, 16'hBEEF);

        // address aliasing
        store(16'h0305, 16'h1234);
        step();
        load(16'h0005, 2'd3);
        step();
        idle();
        step();
        chk("alias_wbData", wbData, 16'h1234);
        chk("alias_rdWb", {14'd0, rdWb}, 16'h0003);

        // conditional jumps
        idle(); JCMem = 1; NEQMem = 1; zeroOut = 0; ulaJumpOut = 16'h0040;
        step();
        chk("bne_pcSrc", {15'd0, pcSrc}, 16'h0001);
        chk("bne_jumpAddr", jumpAddr, 16'h0040);
        chk("bne_flush", {15'd0, flush}, 16'h0001);
        idle();
        step();
        chk("bne_flush_end", {15'd0, flush}, 16'h0000);
        idle(); JCMem = 1; NEQMem = 1; zeroOut = 1; ulaJumpOut = 16'h0040;
        step();
        chk("bne_nt_pcSrc", {15'd0, pcSrc}, 16'h0000);
        chk("bne_nt_flush", {15'd0, flush}, 16'h0000);
        idle(); JCMem = 1; NEQMem = 0; zeroOut = 1; ulaJumpOut = 16'h0044;
        step();
        chk("beq_pcSrc", {15'd0, pcSrc}, 16'h0001);
        idle(); JMem = 1; JCMem = 1; NEQMem = 1; zeroOut = 1; ulaJumpOut = 16'h0077;
        step();
        chk("jmp_pcSrc", {15'd0, pcSrc}, 16'h0001);
        chk("jmp_jumpAddr", jumpAddr, 16'h0077);
        idle();
        step();

        // simultaneous store and load: store wins
        store(16'h0020, 16'h5555); RMMem = 1; rdIn = 2'd1;
        #1;
        chk("sim_stall", {15'd0, stall}, 16'h0000);
        step();
        chk("sim_WRWb", {15'd0, WRWb}, 16'h0000);
        load(16'h0020, 2'd0);
        step();
        idle();
        step();
        chk("sim_mem", wbData, 16'h5555);
        chk("sim_rdWb", {14'd0, rdWb}, 16'h0000);

        // reset during RD_WAIT
        load(16'h0010, 2'd2);
        step();
        idle();
        #2;
        resetN = 0;
        #1;
        chk("rrd_stall", {15'd0, stall}, 16'h0000);
        chk("rrd_WRWb", {15'd0, WRWb}, 16'h0000);
        chk("rrd_wbData", wbData, 16'h0000);
        #3;
        resetN = 1;
        step();
        chk("rrd_post_WRWb", {15'd0, WRWb}, 16'h0000);
        chk("rrd_post_wbData", wbData, 16'h0000);
        step();
        chk("rrd_post2_WRWb", {15'd0, WRWb}, 16'h0000);

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
